sonic_vc_param_adapter_fifo: RTL

SONIC_VC_PARAM_ADAPTER_FIFO -- requirements
Module: sonic_vc_param_adapter_fifo

---
 rtl/sonic_vc_fifo_pkg.sv | 25 ++
 rtl/sonic_vc_fifo_ram.sv | 33 +++
 rtl/sonic_vc_param_adapter_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/sonic_vc_fifo_pkg.sv
// Shared sizing helpers for the sonic VC FIFO family.
package sonic_vc_fifo_pkg;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A fill level must be able to represent 0..depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  localparam int unsigned DEFAULT_DEPTH  = 8;
  localparam int unsigned DEFAULT_FILL_W = fill_width(DEFAULT_DEPTH);

endpackage

// File: rtl/sonic_vc_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
module sonic_vc_fifo_ram
  import sonic_vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 133,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [clog2(DEPTH)-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  input  logic [clog2(DEPTH)-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; rd_data holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sonic_vc_param_adapter_fifo.sv
// Show-ahead FIFO: RAM backing store plus the RAM read register acting as head.
module sonic_vc_param_adapter_fifo
  import sonic_vc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 133,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  input  logic                            out_ready,
  output logic [fill_width(DEPTH)-1:0]    fill_level,
  output logic                            almost_full,
  output logic                            almost_empty
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned FW = fill_width(DEPTH);

  // Parameter legality, caught at elaboration.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sonic_vc_param_adapter_fifo: DATA_WIDTH must be >= 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sonic_vc_param_adapter_fifo: DEPTH must be a power of two >= 4");
  end
  if ((AF_THRESH > DEPTH) || (AE_THRESH > DEPTH)) begin : g_bad_thresh
    $error("sonic_vc_param_adapter_fifo: thresholds must lie within 0..DEPTH");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] ram_cnt;   // entries in RAM not yet fetched into the head register
  logic          wr_en_c;
  logic          pop_c;
  logic          rd_en_c;

  // Handshake decode; flush discards any concurrent write or pop.
  always_comb begin
    wr_en_c = in_valid && in_ready && !flush;
    pop_c   = out_valid && out_ready && !flush;
    rd_en_c = (ram_cnt != '0) && (!out_valid || out_ready) && !flush;
  end

  // Status flags depend on registered fill_level only.
  always_comb begin
    in_ready     = (fill_level != FW'(DEPTH));
    almost_full  = (fill_level >= FW'(AF_THRESH));
    almost_empty = (fill_level <= FW'(AE_THRESH));
  end

  // Pointer, occupancy and head-valid state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      fill_level <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      fill_level <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ram_cnt    <= ram_cnt + FW'(wr_en_c) - FW'(rd_en_c);
      fill_level <= fill_level + FW'(wr_en_c) - FW'(pop_c);
      if (rd_en_c) begin
        out_valid <= 1'b1;
      end else if (pop_c) begin
        out_valid <= 1'b0;
      end
    end
  end

  sonic_vc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (rd_en_c),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule
